// File: rtl/heq_lut_sequencer_pkg.sv
// Shared definitions for the histogram-equalisation LUT sequencer:
// FSM state encoding, default frame constants and the x*255 scaling helper.
package heq_pkg;

    localparam int HEQ_NUM_BINS  = 256;
    localparam int HEQ_PIX_TOTAL = 64;
    localparam int HEQ_DYN_MAX   = 255;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SCAN_RD,
        ST_SCAN_CHK,
        ST_CALC_RD,
        ST_CALC_EVAL,
        ST_CALC_ISSUE,
        ST_CALC_WAIT,
        ST_WRITE,
        ST_DONE
    } heq_state_t;

    // x*255 without a multiplier: shift by 8 and subtract once.
    function automatic logic [31:0] heq_scale(input logic [31:0] x);
        return (x << 8) - x;
    endfunction

endpackage

// File: rtl/heq_lut_sequencer_cdf_min_scan.sv
// First-non-zero scan over the CDF memory. Owns the scan bin counter and the
// cdf_min register; the caller presents read data and pulses check once per bin.
module heq_cdf_min_scan
    import heq_pkg::*;
#(
    parameter int NUM_BINS = HEQ_NUM_BINS,
    parameter int ADDR_W   = 8,
    parameter int CDF_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              check,
    input  logic [CDF_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] bin,
    output logic              hit,
    output logic              last,
    output logic [CDF_W-1:0]  cdf_min
);

    assign hit  = check && (rd_data != '0);
    assign last = (bin == ADDR_W'(NUM_BINS - 1));

    // Advance through zero entries; stop and latch on the first non-zero one.
    // An all-zero memory leaves cdf_min at 0 with bin parked on the last entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin     <= '0;
            cdf_min <= '0;
        end else if (clear) begin
            bin     <= '0;
            cdf_min <= '0;
        end else if (check) begin
            if (rd_data != '0)
                cdf_min <= rd_data;
            else if (!last)
                bin <= bin + 1'b1;
        end
    end

endmodule

// File: rtl/heq_lut_sequencer.sv
// Histogram-equalisation mapping controller. Finds cdf_min, then walks every
// bin through the external divider and writes g = (cdf-cdf_min)*DYN_MAX /
// (PIX_TOTAL-cdf_min) into the LUT, one write per bin in ascending order.
// Optional macro HEQ_DIV_TIMEOUT_EN adds a divider watchdog and sticky err.
module heq_lut_sequencer
    import heq_pkg::*;
#(
    parameter int NUM_BINS  = HEQ_NUM_BINS,
    parameter int ADDR_W    = 8,
    parameter int CDF_W     = 16,
    parameter int DIV_W     = 16,
    parameter int PIX_TOTAL = HEQ_PIX_TOTAL,
    parameter int DYN_MAX   = HEQ_DYN_MAX,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] cdf_rd_addr,
    input  logic [CDF_W-1:0]  cdf_rd_data,
    output logic              div_enable,
    output logic [DIV_W-1:0]  div_dividend,
    output logic [DIV_W-1:0]  div_divisor,
    input  logic              div_done,
    input  logic [7:0]        div_quotient,
    output logic              lut_wr_en,
    output logic [ADDR_W-1:0] lut_wr_addr,
    output logic [7:0]        lut_wr_data,
    output logic [CDF_W-1:0]  cdf_min,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The largest dividend must fit the divider operand width.
    generate
        if ((PIX_TOTAL * DYN_MAX >= 2 ** DIV_W) || (TIMEOUT < 1)) begin : g_bad_cfg
            $error("heq_lut_sequencer: PIX_TOTAL*DYN_MAX overflows DIV_W or TIMEOUT < 1");
        end
    endgenerate

    heq_state_t        state;
    logic [ADDR_W-1:0] bin;

    logic [ADDR_W-1:0] scan_bin;
    logic              scan_hit;
    logic              scan_last;
    logic              scan_clear;
    logic              scan_check;

    assign scan_clear = (state == ST_IDLE) && start;
    assign scan_check = (state == ST_SCAN_CHK);

    heq_cdf_min_scan #(
        .NUM_BINS (NUM_BINS),
        .ADDR_W   (ADDR_W),
        .CDF_W    (CDF_W)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (scan_clear),
        .check   (scan_check),
        .rd_data (cdf_rd_data),
        .bin     (scan_bin),
        .hit     (scan_hit),
        .last    (scan_last),
        .cdf_min (cdf_min)
    );

    // Per-bin evaluation terms, valid while CDF read data for bin is present.
    logic              below_min;
    logic              flat_frame;
    logic [CDF_W-1:0]  cdf_diff;
    logic [DIV_W-1:0]  divisor_c;
    logic [DIV_W-1:0]  dividend_c;
    logic              last_bin;

    assign below_min  = cdf_rd_data < cdf_min;
    assign cdf_diff   = cdf_rd_data - cdf_min;
    assign divisor_c  = DIV_W'(PIX_TOTAL) - DIV_W'(cdf_min);
    assign flat_frame = (divisor_c == '0);
    assign dividend_c = DIV_W'(heq_scale(32'(cdf_diff)));
    assign last_bin   = (bin == ADDR_W'(NUM_BINS - 1));

`ifdef HEQ_DIV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Main sequencer: scan for cdf_min, then read/evaluate/divide/write per bin.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bin          <= '0;
            cdf_rd_addr  <= '0;
            div_enable   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            lut_wr_en    <= 1'b0;
            lut_wr_addr  <= '0;
            lut_wr_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef HEQ_DIV_TIMEOUT_EN
            tmo_cnt      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            lut_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        cdf_rd_addr <= '0;
                        state       <= ST_SCAN_RD;
`ifdef HEQ_DIV_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                ST_SCAN_RD: state <= ST_SCAN_CHK;
                ST_SCAN_CHK: begin
                    if (scan_hit || scan_last) begin
                        bin         <= '0;
                        cdf_rd_addr <= '0;
                        state       <= ST_CALC_RD;
                    end else begin
                        cdf_rd_addr <= scan_bin + 1'b1;
                        state       <= ST_SCAN_RD;
                    end
                end
                ST_CALC_RD: state <= ST_CALC_EVAL;
                ST_CALC_EVAL: begin
                    lut_wr_addr <= bin;
                    if (below_min) begin
                        lut_wr_data <= '0;
                        lut_wr_en   <= 1'b1;
                        state       <= ST_WRITE;
                    end else if (flat_frame) begin
                        lut_wr_data <= 8'(DYN_MAX);
                        lut_wr_en   <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        div_dividend <= dividend_c;
                        div_divisor  <= divisor_c;
                        div_enable   <= 1'b1;
                        state        <= ST_CALC_ISSUE;
                    end
                end
                ST_CALC_ISSUE: begin
                    if (div_done) begin
                        div_enable  <= 1'b0;
                        lut_wr_data <= div_quotient;
                        lut_wr_en   <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        state <= ST_CALC_WAIT;
`ifdef HEQ_DIV_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                ST_CALC_WAIT: begin
                    if (div_done) begin
                        div_enable  <= 1'b0;
                        lut_wr_data <= div_quotient;
                        lut_wr_en   <= 1'b1;
                        state       <= ST_WRITE;
                    end
`ifdef HEQ_DIV_TIMEOUT_EN
                    // A silent divider costs this bin a zero entry, not the pass.
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        div_enable  <= 1'b0;
                        err_q       <= 1'b1;
                        lut_wr_data <= '0;
                        lut_wr_en   <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_WRITE: begin
                    if (last_bin) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        bin         <= bin + 1'b1;
                        cdf_rd_addr <= bin + 1'b1;
                        state       <= ST_CALC_RD;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heq_lut_sequencer.sv
// Directed bench for heq_lut_sequencer: CDF RAM model, variable-latency
// divider model, LUT capture, and one task per scenario.
module tb_heq_lut_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  cdf_rd_addr;
    logic [15:0] cdf_rd_data;
    logic        div_enable;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_done;
    logic [7:0]  div_quotient;
    logic        lut_wr_en;
    logic [7:0]  lut_wr_addr;
    logic [7:0]  lut_wr_data;
    logic [15:0] cdf_min;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    heq_lut_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cdf_rd_addr  (cdf_rd_addr),
        .cdf_rd_data  (cdf_rd_data),
        .div_enable   (div_enable),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .lut_wr_en    (lut_wr_en),
        .lut_wr_addr  (lut_wr_addr),
        .lut_wr_data  (lut_wr_data),
        .cdf_min      (cdf_min),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CDF RAM: synchronous read, data one cycle after the address.
    logic [15:0] cdf_mem [256];
    always @(posedge clk) cdf_rd_data <= cdf_mem[cdf_rd_addr];

    // LUT capture and write/done/enable bookkeeping.
    logic [7:0] lut [256];
    int wr_cnt = 0, done_cnt = 0, order_err = 0, en_cycles = 0, exp_addr = 0;
    always @(posedge clk) begin
        if (!reset) begin
            exp_addr = 0;
        end else begin
            if (lut_wr_en) begin
                lut[lut_wr_addr] = lut_wr_data;
                wr_cnt++;
                if (int'(lut_wr_addr) != exp_addr) order_err++;
                exp_addr = (exp_addr == 255) ? 0 : exp_addr + 1;
            end
            if (done) done_cnt++;
            if (div_enable) en_cycles++;
        end
    end

    // Divider model: request on rising div_enable, done after lat cycles,
    // operands and enable must stay put while the request is outstanding.
    int lat_min = 2, lat_max = 2, hang_bin = -1;
    int req_cnt = 0, stab_err = 0, r42_cnt = 0, div_cnt = 0;
    logic [15:0] req_dd, req_dv, r42_dd, r42_dv;
    bit div_busy = 0, en_q = 0;
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (!reset) begin
            div_busy = 0;
            en_q     = 0;
            div_quotient <= '0;
        end else begin
            if (div_busy) begin
                if (div_enable !== 1'b1 || div_dividend !== req_dd || div_divisor !== req_dv)
                    stab_err++;
                if (div_cnt <= 1) begin
                    div_done     <= 1'b1;
                    div_quotient <= (req_dv == 0) ? 8'hff : 8'(req_dd / req_dv);
                    div_busy = 0;
                end else begin
                    div_cnt--;
                end
            end
            if (div_enable && !en_q) begin
                req_cnt++;
                req_dd = div_dividend;
                req_dv = div_divisor;
                if (lut_wr_addr == 8'd42) begin
                    r42_cnt++;
                    r42_dd = div_dividend;
                    r42_dv = div_divisor;
                end
                if (hang_bin != int'(lut_wr_addr)) begin
                    div_busy = 1;
                    div_cnt  = $urandom_range(lat_max, lat_min);
                end
            end
            en_q = div_enable;
        end
    end

    task automatic load_ramp();
        for (int b = 0; b < 256; b++)
            cdf_mem[b] = (b < 10) ? 16'd0 : (b <= 73) ? 16'(b - 9) : 16'd64;
    endtask

    task automatic load_flat();
        for (int b = 0; b < 256; b++)
            cdf_mem[b] = (b < 100) ? 16'd0 : 16'd64;
    endtask

    // Reference mapping from the equalisation formula over the loaded frame.
    function automatic int model_mismatches();
        int mn = 0, n = 0, e;
        bit found = 0;
        for (int i = 0; i < 256; i++)
            if (!found && cdf_mem[i] != 0) begin mn = int'(cdf_mem[i]); found = 1; end
        for (int b = 0; b < 256; b++) begin
            if (int'(cdf_mem[b]) < mn) e = 0;
            else if (mn == 64)         e = 255;
            else                       e = ((int'(cdf_mem[b]) - mn) * 255) / (64 - mn);
            if (int'(lut[b]) != e) n++;
        end
        return n;
    endfunction

    task automatic run_pass(input int restart_at, output bit got_done, output bit busy_low);
        int n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 0;
        busy_low = 0;
        while (n < 20000 && !got_done) begin
            start = (n == restart_at);
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) begin
                got_done = 1;
                busy_low = (busy === 1'b0);
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cdf_rd_addr, div_enable, div_dividend, div_divisor, lut_wr_en, lut_wr_addr, lut_wr_data} !== '0) begin
            bad++;
            $display("FAIL reset_datapath: got %h expected 0",
                     {cdf_rd_addr, div_enable, div_dividend, div_divisor, lut_wr_en, lut_wr_addr, lut_wr_data});
        end
        total++;
        if ({cdf_min, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_status: got %h expected 0", {cdf_min, busy, done, err});
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int w0 = wr_cnt, d0 = done_cnt, o0 = order_err, z = 0, mm;
        bit gd, bl;
        lat_min = 3; lat_max = 3;
        load_ramp();
        run_pass(-1, gd, bl);
        total++; if (!gd) begin bad++; $display("FAIL ramp_done: got no done expected done within bound"); end
        total++; if (!bl) begin bad++; $display("FAIL ramp_busy_at_done: got busy=%b expected 0", busy); end
        total++; if (cdf_min !== 16'd1) begin bad++; $display("FAIL ramp_cdf_min: got %0d expected 1", cdf_min); end
        for (int b = 0; b < 10; b++) if (lut[b] !== 8'd0) z++;
        total++; if (z != 0) begin bad++; $display("FAIL ramp_lut_0_9: got %0d nonzero expected 0", z); end
        total++; if (lut[10] !== 8'd0) begin bad++; $display("FAIL ramp_lut10: got %0d expected 0", lut[10]); end
        total++; if (lut[42] !== 8'd129) begin bad++; $display("FAIL ramp_lut42: got %0d expected 129", lut[42]); end
        total++; if (lut[255] !== 8'd255) begin bad++; $display("FAIL ramp_lut255: got %0d expected 255", lut[255]); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ramp_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (wr_cnt - w0 != 256) begin bad++; $display("FAIL ramp_writes: got %0d expected 256", wr_cnt - w0); end
        total++; if (order_err != o0) begin bad++; $display("FAIL ramp_order: got %0d out-of-order expected 0", order_err - o0); end
        mm = model_mismatches();
        total++; if (mm != 0) begin bad++; $display("FAIL ramp_lut_model: got %0d mismatches expected 0", mm); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ramp_err: got %b expected 0", err); end
    endtask

    task automatic test_flat();
        int w0 = wr_cnt, d0 = done_cnt, e0 = en_cycles, r0 = req_cnt, z = 0, f = 0;
        bit gd, bl;
        load_flat();
        run_pass(-1, gd, bl);
        total++; if (!gd) begin bad++; $display("FAIL flat_done: got no done expected done within bound"); end
        total++; if (cdf_min !== 16'd64) begin bad++; $display("FAIL flat_cdf_min: got %0d expected 64", cdf_min); end
        for (int b = 0; b < 100; b++) if (lut[b] !== 8'd0) z++;
        for (int b = 100; b < 256; b++) if (lut[b] !== 8'd255) f++;
        total++; if (z != 0) begin bad++; $display("FAIL flat_lut_low: got %0d nonzero expected 0", z); end
        total++; if (f != 0) begin bad++; $display("FAIL flat_lut_high: got %0d not-255 expected 0", f); end
        total++; if (en_cycles != e0 || req_cnt != r0) begin
            bad++; $display("FAIL flat_no_divider: got %0d enable cycles expected 0", en_cycles - e0);
        end
        total++; if (wr_cnt - w0 != 256 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL flat_counts: got writes=%0d done=%0d expected 256/1", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_div_latency();
        int d0 = done_cnt, s0 = stab_err, k0 = r42_cnt, mm;
        bit gd, bl;
        lat_min = 1; lat_max = 20;
        load_ramp();
        run_pass(-1, gd, bl);
        total++; if (!gd || done_cnt - d0 != 1) begin bad++; $display("FAIL lat_done: got %0d done pulses expected 1", done_cnt - d0); end
        total++; if (r42_cnt - k0 != 1) begin bad++; $display("FAIL lat_req42: got %0d requests expected 1", r42_cnt - k0); end
        total++; if (r42_dd !== 16'd8160) begin bad++; $display("FAIL lat_dividend: got %0d expected 8160", r42_dd); end
        total++; if (r42_dv !== 16'd63) begin bad++; $display("FAIL lat_divisor: got %0d expected 63", r42_dv); end
        total++; if (lut[42] !== 8'd129) begin bad++; $display("FAIL lat_lut42: got %0d expected 129", lut[42]); end
        total++; if (stab_err != s0) begin bad++; $display("FAIL lat_operand_stable: got %0d violations expected 0", stab_err - s0); end
        mm = model_mismatches();
        total++; if (mm != 0) begin bad++; $display("FAIL lat_lut_model: got %0d mismatches expected 0", mm); end
    endtask

    task automatic test_back_to_back_start();
        int w0 = wr_cnt, d0 = done_cnt, o0 = order_err, mm;
        bit gd, bl;
        lat_min = 2; lat_max = 5;
        load_ramp();
        run_pass(300, gd, bl);
        total++; if (!gd || done_cnt - d0 != 1) begin bad++; $display("FAIL restart_done: got %0d done pulses expected 1", done_cnt - d0); end
        total++; if (wr_cnt - w0 != 256 || order_err != o0) begin
            bad++; $display("FAIL restart_writes: got %0d writes %0d out-of-order expected 256/0", wr_cnt - w0, order_err - o0);
        end
        mm = model_mismatches();
        total++; if (mm != 0) begin bad++; $display("FAIL restart_lut_model: got %0d mismatches expected 0", mm); end
    endtask

    task automatic test_reset_mid_pass();
        int n = 0, w0, d0, mm;
        bit gd, bl;
        lat_min = 20; lat_max = 20;
        load_ramp();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (div_enable !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        total++; if (div_enable !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_waiting: got enable=%b busy=%b expected 1/1", div_enable, busy);
        end
        w0 = wr_cnt;
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cdf_rd_addr, div_enable, div_dividend, div_divisor, lut_wr_en, lut_wr_addr, lut_wr_data} !== '0) begin
            bad++;
            $display("FAIL rstmid_datapath: got %h expected 0",
                     {cdf_rd_addr, div_enable, div_dividend, div_divisor, lut_wr_en, lut_wr_addr, lut_wr_data});
        end
        total++; if ({cdf_min, busy, done, err} !== '0) begin
            bad++; $display("FAIL rstmid_status: got %h expected 0", {cdf_min, busy, done, err});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (wr_cnt != w0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_abort: got %0d writes busy=%b expected 0/0", wr_cnt - w0, busy);
        end
        lat_min = 1; lat_max = 4;
        w0 = wr_cnt;
        d0 = done_cnt;
        run_pass(-1, gd, bl);
        total++; if (!gd || wr_cnt - w0 != 256 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL rstmid_repass: got writes=%0d done=%0d expected 256/1", wr_cnt - w0, done_cnt - d0);
        end
        mm = model_mismatches();
        total++; if (mm != 0) begin bad++; $display("FAIL rstmid_lut_model: got %0d mismatches expected 0", mm); end
    endtask

`ifdef HEQ_DIV_TIMEOUT_EN
    task automatic test_div_timeout();
        int w0 = wr_cnt, d0 = done_cnt;
        bit gd, bl;
        lat_min = 2; lat_max = 2;
        hang_bin = 50;
        load_ramp();
        run_pass(-1, gd, bl);
        hang_bin = -1;
        total++; if (!gd || done_cnt - d0 != 1) begin bad++; $display("FAIL tmo_done: got %0d done pulses expected 1", done_cnt - d0); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b expected 1", err); end
        total++; if (lut[50] !== 8'd0) begin bad++; $display("FAIL tmo_lut50: got %0d expected 0", lut[50]); end
        total++; if (lut[51] !== 8'd165 || wr_cnt - w0 != 256) begin
            bad++; $display("FAIL tmo_continue: got lut51=%0d writes=%0d expected 165/256", lut[51], wr_cnt - w0);
        end
        run_pass(-1, gd, bl);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int b = 0; b < 256; b++) begin
            cdf_mem[b] = '0;
            lut[b]     = '0;
        end
        test_reset();
        test_ramp();
        test_flat();
        test_div_latency();
        test_back_to_back_start();
        test_reset_mid_pass();
`ifdef HEQ_DIV_TIMEOUT_EN
        test_div_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heq_lut_sequencer.md
Name: heq_lut_sequencer

Overview:
- Controller for the histogram-equalisation mapping stage.
- On start, it scans the CDF memory to find cdf_min, the first non-zero CDF entry.
- It then sequences every bin through the shared binary divider, computing g = ((cdf - cdf_min)*DYN_MAX)/(PIX_TOTAL - cdf_min), and writes each quotient into the equalisation LUT.
- It sits between the CDF RAM, the divider and the LUT RAM, and reports busy/done to the top-level frame controller.

Parameters:
- NUM_BINS, 256, number of histogram bins / LUT entries
- ADDR_W, 8, bin address width (log2 NUM_BINS)
- CDF_W, 16, CDF entry width
- DIV_W, 16, divider operand width
- PIX_TOTAL, 64, pixels per frame (last CDF value)
- DYN_MAX, 255, output dynamic range maximum
- TIMEOUT, 64, divider watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (reset==0 resets on posedge clk)
- start  in  1  one-cycle pulse; begins a frame pass
- cdf_rd_addr  out  ADDR_W  CDF RAM read address; data returns 1 cycle later
- cdf_rd_data  in  CDF_W  CDF RAM read data
- div_enable  out  1  divider request; held until div_done
- div_dividend  out  DIV_W  divider dividend
- div_divisor  out  DIV_W  divider divisor
- div_done  in  1  divider completion pulse
- div_quotient  in  8  divider result, valid while div_done=1
- lut_wr_en  out  1  LUT write strobe
- lut_wr_addr  out  ADDR_W  LUT write address
- lut_wr_data  out  8  LUT write data
- cdf_min  out  CDF_W  registered cdf_min of the current/last pass
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last LUT write
- err  out  1  sticky divider-timeout flag; tied 0 unless DIV_TIMEOUT_EN

Behaviour:
- Reset: every output is 0, including the address and data outputs, cdf_min, busy, done and err; FSM enters IDLE.
- Reset asserted mid-pass aborts immediately, with no further LUT writes.
- FSM states:
  - IDLE: waits for start.
  - SCAN_RD: issues cdf_rd_addr = bin.
  - SCAN_CHK: if cdf_rd_data != 0, latch cdf_min and go to CALC_RD with bin = 0; else bin++. At bin = NUM_BINS-1 with all entries zero, cdf_min = 0.
  - CALC_RD: issues the read for bin.
  - CALC_EVAL: decides between divider issue and direct write.
  - CALC_ISSUE/CALC_WAIT: drives div_enable=1 with stable operands until div_done is sampled 1.
  - WRITE: one-cycle lut_wr_en.
  - DONE: pulses done, returns to IDLE.
- start is ignored while busy=1.
- CALC_EVAL rules:
  - cdf < cdf_min → write 0 directly, no divider use.
  - divisor PIX_TOTAL - cdf_min == 0 (single-valued frame) → write DYN_MAX directly.
  - Otherwise dividend = (cdf - cdf_min)*DYN_MAX computed as (x<<8) - x, zero-extended/truncated to DIV_W; divisor = PIX_TOTAL - cdf_min.
  - Elaboration-time check: PIX_TOTAL*DYN_MAX < 2**DIV_W.
- Divider handshake:
  - div_enable rises in CALC_ISSUE and drops in the cycle after div_done is sampled.
  - div_quotient is captured on the div_done cycle.
  - div_done while div_enable=0 is ignored.
- Writes go in bin order 0..NUM_BINS-1, exactly one per bin; the address wraps nowhere. The pass ends after bin NUM_BINS-1 is written.
- done is asserted the cycle after the final write. busy falls in that same cycle.

Optional Feature:
- Macro HEQ_DIV_TIMEOUT_EN.
- Defined:
  - A counter runs during CALC_WAIT.
  - If div_done is absent for TIMEOUT cycles: drop div_enable, set err sticky (cleared only by reset or the next accepted start), write 0 for that bin, and continue the pass.
- Undefined: no counter; err is tied 0; CALC_WAIT waits indefinitely.

Decomposition:
- Package heq_pkg: FSM state encoding, default constants NUM_BINS/PIX_TOTAL/DYN_MAX, and the scale function (x<<8)-x.
- One natural sub-module, heq_cdf_min_scan: the first-non-zero scan counter/comparator, reused by later histogram passes.
- The divider itself stays external.

Test Plan:
- CDF all 0 for bins 0..9 and 1 for bin 10, linear up to 64 at bin 73, 64 thereafter:
  - cdf_min=1;
  - LUT[0..9]=0;
  - LUT[10]=0;
  - LUT[255]=255;
  - done pulses once; 256 writes total.
- Frame of all pixels equal (CDF 0 up to bin 99, 64 from bin 100):
  - cdf_min=64;
  - LUT[0..99]=0;
  - LUT[100..255]=255;
  - div_enable is never asserted.
- Divider model with random 1..20-cycle latency, bin cdf=33, cdf_min=1:
  - dividend=8160, divisor=63;
  - lut_wr_data=129;
  - operands stable throughout the request.
- start pulsed again mid-pass:
  - ignored;
  - write sequence unchanged;
  - exactly one done.
- reset driven 0 during CALC_WAIT:
  - next cycle all outputs 0, FSM in IDLE;
  - a new start yields a full correct pass.
- With HEQ_DIV_TIMEOUT_EN, divider model never asserts div_done at bin 50:
  - err=1 after 64 cycles;
  - LUT[50]=0;
  - pass completes with done.
